// File: rtl/hazard_pkg.sv
// Shared types and helpers for the SCU pipeline hazard controller.
// Latency: none; this file holds types and a pure match function.
// Backpressure: none.
package hazard_pkg;

  localparam int REG_W = 6;

  // EX operand mux selects.
  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } hz_state_t;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr;
    logic             load;
  } slot_t;

  localparam slot_t SLOT_NONE = '0;

  // A slot produces a value that a source needs; r0 is hardwired and never hazards.
  function automatic logic slot_match(input slot_t s, input logic [REG_W-1:0] src,
                                      input logic used);
    return s.valid && s.wr && used && (s.rd == src) && (s.rd != '0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side hazard bundle: ID instruction fields and branch resolve in, hazard controls out.
// Latency: none; wiring only.
// Backpressure: stall from the slave side holds PC and IF/ID on the master side.
interface hazard_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_W = hazard_pkg::REG_W
);

  logic             id_valid;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_rs_used;
  logic             id_rt_used;
  logic [REG_W-1:0] id_rd;
  logic             id_wr;
  logic             id_load;
  logic             br_taken;
  logic             stall;
  logic             bubble;
  logic             flush;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr, id_load, br_taken,
    input  stall, bubble, flush, fwd_a, fwd_b
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_rd, id_wr, id_load, br_taken,
    output stall, bubble, flush, fwd_a, fwd_b
  );

endinterface

// File: rtl/hazard_slot_pipe.sv
// Three-slot EX/MEM/WB tracker of instructions issued from decode.
// Latency: an accepted instruction appears in the EX slot 1 cycle later, MEM 2, WB 3.
// Backpressure: ins_bubble loads an invalid entry into EX instead of id_slot.
module hazard_slot_pipe
  import hazard_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  ins_bubble,
  input  slot_t id_slot,
  output slot_t ex_slot,
  output slot_t mem_slot,
  output slot_t wb_slot
);

  // Shift every slot one stage down the pipe each cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      ex_slot  <= SLOT_NONE;
      mem_slot <= SLOT_NONE;
      wb_slot  <= SLOT_NONE;
    end else begin
      wb_slot  <= mem_slot;
      mem_slot <= ex_slot;
      ex_slot  <= ins_bubble ? SLOT_NONE : id_slot;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/bubble/flush for IF/ID and ID/EX, EX forwarding selects.
// Latency: stall/bubble/flush combinational; fwd_a/fwd_b registered, 1 cycle.
// Backpressure: stall holds decode; build option HAZARD_FWD_EN enables forwarding (else stall on any slot match).
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int REG_W        = hazard_pkg::REG_W
) (
  input logic          clock,
  input logic          reset,
  hazard_ctrl_if.slave hif
);

  // The branch cycle itself is the first flush cycle, so the counter covers the rest.
  localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

  hz_state_t        state, state_n;
  logic [1:0]       cnt, cnt_n;
  slot_t            id_slot, ex_slot, mem_slot, wb_slot;
  logic [REG_W-1:0] src_a, src_b;
  logic             a_ex, a_mem, b_ex, b_mem;
  logic             hazard, accept;
  logic             stall_c, bubble_c, flush_c;

  assign src_a   = hif.id_rs;
  assign src_b   = hif.id_rt;
  assign id_slot = '{valid: 1'b1, rd: hif.id_rd, wr: hif.id_wr, load: hif.id_load};

  assign a_ex  = hif.id_valid && slot_match(ex_slot,  src_a, hif.id_rs_used);
  assign b_ex  = hif.id_valid && slot_match(ex_slot,  src_b, hif.id_rt_used);
  assign a_mem = hif.id_valid && slot_match(mem_slot, src_a, hif.id_rs_used);
  assign b_mem = hif.id_valid && slot_match(mem_slot, src_b, hif.id_rt_used);

  assign accept = hif.id_valid && !stall_c && !flush_c;

  hazard_slot_pipe u_slots (
    .clock      (clock),
    .reset      (reset),
    .ins_bubble (!accept),
    .id_slot    (id_slot),
    .ex_slot    (ex_slot),
    .mem_slot   (mem_slot),
    .wb_slot    (wb_slot)
  );

`ifdef HAZARD_FWD_EN
  fwd_sel_t fwd_a_q, fwd_b_q;
  logic     unused_bits;

  // With forwarding only a load still in EX cannot supply its result in time.
  assign hazard      = ex_slot.load && (a_ex || b_ex);
  assign unused_bits = ^wb_slot;

  // Capture operand selects, from pre-shift slots, for the instruction moving into ID/EX.
  always_ff @(posedge clock) begin
    if (reset) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else if (accept) begin
      fwd_a_q <= a_ex ? FWD_EXMEM : (a_mem ? FWD_MEMWB : FWD_RF);
      fwd_b_q <= b_ex ? FWD_EXMEM : (b_mem ? FWD_MEMWB : FWD_RF);
    end else begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end
  end

  assign hif.fwd_a = fwd_a_q;
  assign hif.fwd_b = fwd_b_q;
`else
  logic a_wb, b_wb;

  // Without forwarding any producer still in flight blocks the reader until it retires.
  assign a_wb      = hif.id_valid && slot_match(wb_slot, src_a, hif.id_rs_used);
  assign b_wb      = hif.id_valid && slot_match(wb_slot, src_b, hif.id_rt_used);
  assign hazard    = a_ex || b_ex || a_mem || b_mem || a_wb || b_wb;
  assign hif.fwd_a = FWD_RF;
  assign hif.fwd_b = FWD_RF;
`endif

  // FSM state and flush counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: a taken branch always wins and (re)arms the flush counter.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (hif.br_taken) begin
      state_n = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      cnt_n   = CNT_LOAD;
    end else begin
      unique case (state)
        RUN: begin
          if (hazard) state_n = STALL;
        end
        STALL: begin
`ifdef HAZARD_FWD_EN
          state_n = RUN;
`else
          state_n = hazard ? STALL : RUN;
`endif
        end
        FLUSH: begin
          if (cnt <= 2'd1) begin
            state_n = RUN;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt - 2'd1;
          end
        end
        default: begin
          state_n = RUN;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs: flush masks any stall; either one squashes the ID/EX load.
  always_comb begin
    flush_c  = hif.br_taken || (state == FLUSH);
    stall_c  = hazard && !flush_c;
    bubble_c = stall_c || flush_c;
  end

  assign hif.stall  = stall_c;
  assign hif.bubble = bubble_c;
  assign hif.flush  = flush_c;

endmodule
